// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the pipelined LEGv8 control unit: opcodes, ALU op codes,
// the per-stage control bundle and the bubble constant.
package cpu_ctrl_pkg;

    localparam int INSTR_W_P = 32;
    localparam int ALUOP_W_P = 3;
    localparam int REG_AW_P  = 5;
    localparam int OPC_W     = 11;

    localparam logic [REG_AW_P-1:0] XZR = 5'd31;

    // '?' bits are immediate/condition bits that share the opcode field
    localparam logic [OPC_W-1:0] OP_LDUR = 11'b11111000010;
    localparam logic [OPC_W-1:0] OP_STUR = 11'b11111000000;
    localparam logic [OPC_W-1:0] OP_ADDI = 11'b1001000100?;
    localparam logic [OPC_W-1:0] OP_ADDS = 11'b10101011000;
    localparam logic [OPC_W-1:0] OP_SUBS = 11'b11101011000;
    localparam logic [OPC_W-1:0] OP_AND  = 11'b10001010000;
    localparam logic [OPC_W-1:0] OP_EOR  = 11'b11001010000;
    localparam logic [OPC_W-1:0] OP_LSR  = 11'b11010011010;
    localparam logic [OPC_W-1:0] OP_B    = 11'b000101?????;
    localparam logic [OPC_W-1:0] OP_CBZ  = 11'b10110100???;
    localparam logic [OPC_W-1:0] OP_BLT  = 11'b01010100???;

    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_ADD  = 3'b010,
        ALU_SUB  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_OR   = 3'b101,
        ALU_XOR  = 3'b110,
        ALU_LSR  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                mem_to_reg;
        logic                mem_write;
        logic                mem_read;
        logic                alu_src;
        alu_op_e             alu_op;
        logic                set_flags;
        logic [REG_AW_P-1:0] rd;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '{valid: 1'b0, reg_write: 1'b0, mem_to_reg: 1'b0,
                                        mem_write: 1'b0, mem_read: 1'b0, alu_src: 1'b0,
                                        alu_op: ALU_PASS, set_flags: 1'b0, rd: 5'd0};

    // signed less-than from an {N,Z,V,C} vector
    function automatic logic lt_cond(input logic [3:0] nzvc);
        return nzvc[3] ^ nzvc[1];
    endfunction

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Bundle of all ID-stage inputs and per-stage control outputs of the control unit.
interface pipelined_control_unit_if
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_P,
    parameter int ALUOP_W = ALUOP_W_P,
    parameter int REG_AW  = REG_AW_P
);
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               rd_zero;
    logic               ext_stall;
    logic               alu_zero;
    logic               alu_negative;
    logic               alu_overflow;
    logic               alu_carry_out;
    logic               id_Reg2Loc;
    logic               id_UncondBr;
    logic               id_BrTaken;
    logic               stall_if;
    logic               illegal;
    logic               ex_ALUSrc;
    logic [ALUOP_W-1:0] ex_ALUOp;
    logic               ex_SetFlags;
    logic               mem_MemWrite;
    logic               mem_MemRead;
    logic               wb_RegWrite;
    logic               wb_MemToReg;
    logic [REG_AW-1:0]  wb_Rd;
    logic [3:0]         flags_q;

    modport slave (
        input  instr, instr_valid, rd_zero, ext_stall,
               alu_zero, alu_negative, alu_overflow, alu_carry_out,
        output id_Reg2Loc, id_UncondBr, id_BrTaken, stall_if, illegal,
               ex_ALUSrc, ex_ALUOp, ex_SetFlags, mem_MemWrite, mem_MemRead,
               wb_RegWrite, wb_MemToReg, wb_Rd, flags_q
    );

    modport master (
        output instr, instr_valid, rd_zero, ext_stall,
               alu_zero, alu_negative, alu_overflow, alu_carry_out,
        input  id_Reg2Loc, id_UncondBr, id_BrTaken, stall_if, illegal,
               ex_ALUSrc, ex_ALUOp, ex_SetFlags, mem_MemWrite, mem_MemRead,
               wb_RegWrite, wb_MemToReg, wb_Rd, flags_q
    );
endinterface

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder: control bundle, ID-stage branch/operand
// selects and which source registers the instruction actually reads.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0]    opcode,
    input  logic [REG_AW_P-1:0] rd,
    output ctrl_bundle_t        bundle,
    output logic                illegal,
    output logic                reg2loc,
    output logic                uncond_br,
    output logic                is_cbz,
    output logic                is_blt,
    output logic                uses_rn,
    output logic                uses_p2
);

    // opcode table; illegal opcodes fall through to a bubble
    always_comb begin
        bundle    = BUBBLE;
        illegal   = 1'b0;
        reg2loc   = 1'b0;
        uncond_br = 1'b0;
        is_cbz    = 1'b0;
        is_blt    = 1'b0;
        uses_rn   = 1'b0;
        uses_p2   = 1'b0;
        casez (opcode)
            OP_LDUR: begin
                bundle.reg_write  = 1'b1;
                bundle.mem_to_reg = 1'b1;
                bundle.mem_read   = 1'b1;
                bundle.alu_src    = 1'b1;
                bundle.alu_op     = ALU_ADD;
                uses_rn           = 1'b1;
            end
            OP_STUR: begin
                bundle.mem_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.alu_op    = ALU_ADD;
                uses_rn          = 1'b1;
                uses_p2          = 1'b1;
            end
            OP_ADDI: begin
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.alu_op    = ALU_ADD;
                uses_rn          = 1'b1;
            end
            OP_ADDS, OP_SUBS, OP_AND, OP_EOR: begin
                bundle.reg_write = 1'b1;
                bundle.set_flags = (opcode == OP_ADDS) || (opcode == OP_SUBS);
                bundle.alu_op    = (opcode == OP_ADDS) ? ALU_ADD :
                                   (opcode == OP_SUBS) ? ALU_SUB :
                                   (opcode == OP_AND)  ? ALU_AND : ALU_XOR;
                reg2loc          = 1'b1;
                uses_rn          = 1'b1;
                uses_p2          = 1'b1;
            end
            OP_LSR: begin
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.alu_op    = ALU_LSR;
                uses_rn          = 1'b1;
            end
            OP_B:    uncond_br = 1'b1;
            OP_CBZ: begin
                is_cbz  = 1'b1;
                uses_p2 = 1'b1;
            end
            OP_BLT:  is_blt = 1'b1;
            default: illegal = 1'b1;
        endcase
        // XZR is never a real destination
        if (illegal) begin
            bundle = BUBBLE;
        end else begin
            bundle.valid     = 1'b1;
            bundle.rd        = rd;
            bundle.reg_write = bundle.reg_write & (rd != XZR);
        end
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// LEGv8 pipeline control: ID decode and branch resolution, load-use / flag
// hazard stalls, ID/EX, EX/MEM, MEM/WB control registers and the NZVC register.
module pipelined_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_W  = INSTR_W_P,
    parameter int ALUOP_W  = ALUOP_W_P,
    parameter int REG_AW   = REG_AW_P,
    parameter int FLAG_FWD = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    pipelined_control_unit_if.slave  bus
);

    localparam logic FWD_ON = (FLAG_FWD != 0);

    ctrl_bundle_t      dec_s, id_bundle_s, ex_r, mem_r, wb_r;
    logic [3:0]        flags_r;
    logic              dec_illegal_s, reg2loc_s, uncond_s, is_cbz_s, is_blt_s;
    logic              uses_rn_s, uses_p2_s;
    logic [REG_AW-1:0] rn_s, rm_s, rt_s, p2_s;
    logic              ex_load_s, ex_sets_s, load_use_s, flag_wait_s, stall_s;
    logic              lt_s, taken_s;
    logic              unused_s;

    ctrl_decode u_decode (
        .opcode    (bus.instr[INSTR_W-1 -: OPC_W]),
        .rd        (bus.instr[REG_AW-1:0]),
        .bundle    (dec_s),
        .illegal   (dec_illegal_s),
        .reg2loc   (reg2loc_s),
        .uncond_br (uncond_s),
        .is_cbz    (is_cbz_s),
        .is_blt    (is_blt_s),
        .uses_rn   (uses_rn_s),
        .uses_p2   (uses_p2_s)
    );

    assign rn_s = bus.instr[5 +: REG_AW];
    assign rm_s = bus.instr[16 +: REG_AW];
    assign rt_s = bus.instr[REG_AW-1:0];
    assign p2_s = reg2loc_s ? rm_s : rt_s;

    // a load into XZR produces nothing a reader could wait for
    assign ex_load_s   = ex_r.valid & ex_r.mem_read & (ex_r.rd != XZR);
    assign ex_sets_s   = ex_r.valid & ex_r.set_flags;
    assign load_use_s  = bus.instr_valid & ex_load_s &
                         ((uses_rn_s & (rn_s == ex_r.rd)) | (uses_p2_s & (p2_s == ex_r.rd)));
    assign flag_wait_s = bus.instr_valid & is_blt_s & ex_sets_s & ~FWD_ON;
    assign stall_s     = load_use_s | flag_wait_s | bus.ext_stall;

    // branch resolution and the bundle handed to ID/EX
    always_comb begin
        lt_s        = 1'b0;
        taken_s     = 1'b0;
        id_bundle_s = BUBBLE;
        if (FWD_ON && ex_sets_s) begin
            lt_s = lt_cond({bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry_out});
        end else begin
            lt_s = lt_cond(flags_r);
        end
        if (bus.instr_valid && !stall_s) begin
            taken_s     = uncond_s | (is_cbz_s & bus.rd_zero) | (is_blt_s & lt_s);
            id_bundle_s = dec_s;
        end else begin
            taken_s     = 1'b0;
            id_bundle_s = BUBBLE;
        end
    end

    // stage registers and NZVC; the back end never stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_r    <= BUBBLE;
            mem_r   <= BUBBLE;
            wb_r    <= BUBBLE;
            flags_r <= 4'b0000;
        end else begin
            if (ex_sets_s) begin
                flags_r <= {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry_out};
            end
            ex_r  <= id_bundle_s;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end
    end

    assign bus.id_Reg2Loc   = reg2loc_s;
    assign bus.id_UncondBr  = uncond_s;
    assign bus.id_BrTaken   = taken_s;
    assign bus.stall_if     = stall_s;
    assign bus.illegal      = bus.instr_valid & dec_illegal_s;
    assign bus.ex_ALUSrc    = ex_r.alu_src;
    assign bus.ex_ALUOp     = ALUOP_W'(ex_r.alu_op);
    assign bus.ex_SetFlags  = ex_r.set_flags;
    assign bus.mem_MemWrite = mem_r.mem_write;
    assign bus.mem_MemRead  = mem_r.mem_read;
    assign bus.wb_RegWrite  = wb_r.reg_write;
    assign bus.wb_MemToReg  = wb_r.mem_to_reg;
    assign bus.wb_Rd        = wb_r.rd;
    assign bus.flags_q      = flags_r;

    assign unused_s = ^{bus.instr[15:10], wb_r.valid, wb_r.mem_write, wb_r.mem_read,
                        wb_r.alu_src, wb_r.alu_op, wb_r.set_flags};

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Two control units (FLAG_FWD=0 as unit 0, FLAG_FWD=1 as unit 1) driven by
// directed and random instruction streams and compared to a behavioural model.
module tb_pipelined_control_unit;

    localparam int C_ILL = 0, C_LDUR = 1, C_STUR = 2, C_ADDI = 3, C_ADDS = 4, C_SUBS = 5;
    localparam int C_AND = 6, C_EOR = 7, C_LSR = 8, C_B = 9, C_CBZ = 10, C_BLT = 11;

    typedef struct packed {
        logic       v, rw, m2r, mw, mr, src;
        logic [2:0] op;
        logic       sf;
        logic [4:0] rd;
    } stage_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0] in_instr [2];
    logic        in_valid [2];
    logic        in_rz    [2];
    logic        in_es    [2];
    logic [3:0]  in_alu   [2];
    logic [4:0]  obs_comb [2];
    logic [17:0] obs_reg  [2];

    pipelined_control_unit_if ifc0 ();
    pipelined_control_unit_if ifc1 ();

    pipelined_control_unit #(.FLAG_FWD(0)) dut0 (.clk(clk), .reset(reset), .bus(ifc0));
    pipelined_control_unit #(.FLAG_FWD(1)) dut1 (.clk(clk), .reset(reset), .bus(ifc1));

    assign ifc0.instr = in_instr[0];  assign ifc1.instr = in_instr[1];
    assign ifc0.instr_valid = in_valid[0];  assign ifc1.instr_valid = in_valid[1];
    assign ifc0.rd_zero = in_rz[0];  assign ifc1.rd_zero = in_rz[1];
    assign ifc0.ext_stall = in_es[0];  assign ifc1.ext_stall = in_es[1];
    assign ifc0.alu_negative = in_alu[0][3];  assign ifc1.alu_negative = in_alu[1][3];
    assign ifc0.alu_zero = in_alu[0][2];  assign ifc1.alu_zero = in_alu[1][2];
    assign ifc0.alu_overflow = in_alu[0][1];  assign ifc1.alu_overflow = in_alu[1][1];
    assign ifc0.alu_carry_out = in_alu[0][0];  assign ifc1.alu_carry_out = in_alu[1][0];

    assign obs_comb[0] = {ifc0.illegal, ifc0.id_Reg2Loc, ifc0.id_UncondBr, ifc0.stall_if, ifc0.id_BrTaken};
    assign obs_comb[1] = {ifc1.illegal, ifc1.id_Reg2Loc, ifc1.id_UncondBr, ifc1.stall_if, ifc1.id_BrTaken};
    assign obs_reg[0] = {ifc0.ex_ALUSrc, ifc0.ex_ALUOp, ifc0.ex_SetFlags, ifc0.mem_MemWrite, ifc0.mem_MemRead,
                         ifc0.wb_RegWrite, ifc0.wb_MemToReg, ifc0.wb_Rd, ifc0.flags_q};
    assign obs_reg[1] = {ifc1.ex_ALUSrc, ifc1.ex_ALUOp, ifc1.ex_SetFlags, ifc1.mem_MemWrite, ifc1.mem_MemRead,
                         ifc1.wb_RegWrite, ifc1.wb_MemToReg, ifc1.wb_Rd, ifc1.flags_q};

    int vectors = 0;
    int miscompares = 0;

    stage_t     m_ex [2], m_mem [2], m_wb [2], m_new [2];
    logic [3:0] m_flags [2];
    logic       m_stall [2], m_hold [2];
    int         pidx [2];
    logic [33:0] dir_prog [$];
    logic        directed;
    logic [3:0]  dir_alu;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int classify(input logic [10:0] op);
        if (op == 11'h7C2) return C_LDUR;
        else if (op == 11'h7C0) return C_STUR;
        else if (op[10:1] == 10'h244) return C_ADDI;
        else if (op == 11'h558) return C_ADDS;
        else if (op == 11'h758) return C_SUBS;
        else if (op == 11'h450) return C_AND;
        else if (op == 11'h650) return C_EOR;
        else if (op == 11'h69A) return C_LSR;
        else if (op[10:5] == 6'h05) return C_B;
        else if (op[10:3] == 8'hB4) return C_CBZ;
        else if (op[10:3] == 8'h54) return C_BLT;
        return C_ILL;
    endfunction

    function automatic stage_t table_entry(input int cls, input logic [4:0] rd);
        stage_t s = '0;
        s.v  = 1'b1;
        s.rd = rd;
        case (cls)
            C_LDUR: begin s.rw = 1'b1; s.m2r = 1'b1; s.mr = 1'b1; s.src = 1'b1; s.op = 3'b010; end
            C_STUR: begin s.mw = 1'b1; s.src = 1'b1; s.op = 3'b010; end
            C_ADDI: begin s.rw = 1'b1; s.src = 1'b1; s.op = 3'b010; end
            C_ADDS: begin s.rw = 1'b1; s.sf = 1'b1; s.op = 3'b010; end
            C_SUBS: begin s.rw = 1'b1; s.sf = 1'b1; s.op = 3'b011; end
            C_AND:  begin s.rw = 1'b1; s.op = 3'b100; end
            C_EOR:  begin s.rw = 1'b1; s.op = 3'b110; end
            C_LSR:  begin s.rw = 1'b1; s.src = 1'b1; s.op = 3'b111; end
            default: ;
        endcase
        if (rd == 5'd31) s.rw = 1'b0;
        return s;
    endfunction

    function automatic logic [31:0] enc(input logic [10:0] op, input logic [4:0] rm, input logic [4:0] rn,
                                        input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd1;
            1: return 5'd2;
            2: return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        logic [10:0] r = 11'($urandom);
        logic [10:0] op;
        case ($urandom_range(0, 11))
            0: op = r;
            1: op = 11'h7C2;
            2: op = 11'h7C0;
            3: op = 11'h488 | (r & 11'h001);
            4: op = 11'h558;
            5: op = 11'h758;
            6: op = 11'h450;
            7: op = 11'h650;
            8: op = 11'h69A;
            9: op = 11'h0A0 | (r & 11'h01F);
            10: op = 11'h5A0 | (r & 11'h007);
            default: op = 11'h2A0 | (r & 11'h007);
        endcase
        w[31:21] = op;
        w[20:16] = pick_reg();
        w[9:5]   = pick_reg();
        w[4:0]   = pick_reg();
        return w;
    endfunction

    task automatic model_comb(input int k);
        int         cls = classify(in_instr[k][31:21]);
        logic [4:0] rn = in_instr[k][9:5], rm = in_instr[k][20:16], rt = in_instr[k][4:0];
        logic       rtype = (cls == C_ADDS) || (cls == C_SUBS) || (cls == C_AND) || (cls == C_EOR);
        logic       reads, lu, fw, lt, taken;
        logic [3:0] fl;
        reads = ((cls >= C_LDUR) && (cls <= C_LSR) && (rn == m_ex[k].rd)) || (rtype && (rm == m_ex[k].rd)) ||
                (((cls == C_STUR) || (cls == C_CBZ)) && (rt == m_ex[k].rd));
        lu = in_valid[k] && m_ex[k].v && m_ex[k].mr && (m_ex[k].rd != 5'd31) && reads;
        fw = in_valid[k] && (cls == C_BLT) && m_ex[k].v && m_ex[k].sf && (k == 0);
        m_stall[k] = lu || fw || in_es[k];
        fl = ((k == 1) && m_ex[k].v && m_ex[k].sf) ? in_alu[k] : m_flags[k];
        lt = fl[3] ^ fl[1];
        taken = in_valid[k] && !m_stall[k] &&
                ((cls == C_B) || ((cls == C_CBZ) && in_rz[k]) || ((cls == C_BLT) && lt));
        if (!in_valid[k] || (cls == C_ILL) || m_stall[k]) m_new[k] = '0;
        else m_new[k] = table_entry(cls, rt);
        check_val($sformatf("comb_u%0d", k), 32'(obs_comb[k]),
                  32'({in_valid[k] && (cls == C_ILL), rtype, cls == C_B, m_stall[k], taken}));
    endtask

    task automatic model_edge(input int k, input logic rst);
        if (rst) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_flags[k] = 4'd0;
        end else begin
            if (m_ex[k].v && m_ex[k].sf) m_flags[k] = in_alu[k];
            m_wb[k]  = m_mem[k];
            m_mem[k] = m_ex[k];
            m_ex[k]  = m_new[k];
        end
        m_hold[k] = m_stall[k] && !rst;
    endtask

    task automatic cycle(input logic rst);
        reset = rst;
        for (int k = 0; k < 2; k++) begin
            if (!m_hold[k]) begin
                if (directed && (pidx[k] < dir_prog.size())) begin
                    {in_rz[k], in_valid[k], in_instr[k]} = dir_prog[pidx[k]];
                    pidx[k]++;
                end else if (directed) begin
                    in_valid[k] = 1'b0; in_instr[k] = 32'd0; in_rz[k] = 1'b0;
                end else begin
                    in_instr[k] = rand_instr();
                    in_valid[k] = ($urandom_range(0, 9) != 0);
                    in_rz[k]    = 1'($urandom);
                end
            end
            in_es[k]  = directed ? 1'b0 : ($urandom_range(0, 9) == 0);
            in_alu[k] = directed ? dir_alu : 4'($urandom);
        end
        #1;
        for (int k = 0; k < 2; k++) model_comb(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k, rst);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("regs_u%0d", k), 32'(obs_reg[k]),
                      32'({m_ex[k].src, m_ex[k].op, m_ex[k].sf, m_mem[k].mw, m_mem[k].mr,
                           m_wb[k].rw, m_wb[k].m2r, m_wb[k].rd, m_flags[k]}));
        end
    endtask

    initial begin
        reset = 1'b1;
        directed = 1'b0;
        dir_alu = 4'd0;
        for (int k = 0; k < 2; k++) begin
            in_instr[k] = 32'd0; in_valid[k] = 1'b0; in_rz[k] = 1'b0; in_es[k] = 1'b0; in_alu[k] = 4'd0;
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_flags[k] = 4'd0;
            m_hold[k] = 1'b0; m_stall[k] = 1'b0; pidx[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("reset_regs_u%0d", k), 32'(obs_reg[k]), 32'd0);
            check_val($sformatf("reset_comb_u%0d", k), 32'(obs_comb[k]), 32'd0);
        end

        // {rd_zero, instr_valid, instr}
        dir_prog.push_back({2'b01, enc(11'h558, 5'd3, 5'd2, 5'd1)});   // ADDS X1,X2,X3
        dir_prog.push_back({2'b01, enc(11'h2A0, 5'd0, 5'd0, 5'd11)});  // B.LT
        dir_prog.push_back({2'b01, enc(11'h7C2, 5'd0, 5'd2, 5'd1)});   // LDUR X1,[X2]
        dir_prog.push_back({2'b01, enc(11'h558, 5'd3, 5'd1, 5'd2)});   // ADDS X2,X1,X3
        dir_prog.push_back({2'b01, enc(11'h7C2, 5'd0, 5'd2, 5'd31)});  // LDUR X31,[X2]
        dir_prog.push_back({2'b01, enc(11'h558, 5'd3, 5'd31, 5'd2)});  // ADDS X2,X31,X3
        dir_prog.push_back({2'b11, enc(11'h5A0, 5'd0, 5'd0, 5'd1)});   // CBZ X1, zero
        dir_prog.push_back({2'b01, enc(11'h5A0, 5'd0, 5'd0, 5'd1)});   // CBZ X1, nonzero
        dir_prog.push_back({2'b10, enc(11'h5A0, 5'd0, 5'd0, 5'd1)});   // CBZ, not valid
        dir_prog.push_back({2'b01, enc(11'h7C0, 5'd0, 5'd2, 5'd1)});   // STUR X1,[X2]
        dir_prog.push_back({2'b01, enc(11'h7FF, 5'd1, 5'd2, 5'd3)});   // illegal
        directed = 1'b1;
        dir_alu = 4'b1000;
        repeat (dir_prog.size() + 8) cycle(1'b0);

        directed = 1'b0;
        for (int n = 0; n < 2000; n++) cycle($urandom_range(0, 99) == 0);

        repeat (3) cycle(1'b0);
        cycle(1'b1);
        for (int k = 0; k < 2; k++) check_val($sformatf("rst_mid_u%0d", k), 32'(obs_reg[k]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
